// File: rtl/bfp_shift_scaler.sv
// bfp_shift_scaler: registered streaming block-floating-point scaler placed
// between FFT butterfly stages. A per-frame right shift, clamped to MAX_SHIFT,
// is applied to complex samples behind a single output register with a
// valid/ready handshake. The block also accumulates the frame exponent and
// flags growth for the next stage.
// Optional macro: BFP_ROUND_EN. Defined: round-half-up. Undefined: truncate.
module bfp_shift_scaler #(
  parameter int W         = 16,
  parameter int FRAME     = 8,
  parameter int SHW       = 3,
  parameter int MAX_SHIFT = 3,
  parameter int EXPW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_re,
  input  logic [W-1:0]    in_im,
  input  logic [SHW-1:0]  shift_amt,
  input  logic            exp_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_re,
  output logic [W-1:0]    out_im,
  output logic            out_last,
  output logic            grow_flag,
  output logic [EXPW-1:0] frame_exp
);
  localparam int CW = $clog2(FRAME);

  logic [CW-1:0]   r_cnt;
  logic [SHW-1:0]  r_slat;
  logic            r_grow_acc;
  logic            r_out_valid;
  logic [W-1:0]    r_out_re;
  logic [W-1:0]    r_out_im;
  logic            r_out_last;
  logic            r_grow;
  logic [EXPW-1:0] r_exp;

  logic            w_acc;
  logic            w_pop;
  logic            w_first;
  logic            w_last_in;
  logic [SHW-1:0]  w_clamp;
  logic [SHW-1:0]  w_s;
  logic [W-1:0]    w_re;
  logic [W-1:0]    w_im;
  logic            w_g;
  logic            w_gbase;

  // Sign-extend one bit, add the rounding bias, shift arithmetically, keep W bits.
  function automatic logic [W-1:0] f_scale(input logic [W-1:0] x, input logic [SHW-1:0] s);
    logic [W:0] ext;
    logic [W:0] bias;
    logic [W:0] sum;
    ext  = {x[W-1], x};
    bias = '0;
`ifdef BFP_ROUND_EN
    if (s != '0) bias = (W+1)'(1) << (s - 1'b1);
`endif
    sum  = ext + bias;
    return W'($signed(sum) >>> s);
  endfunction

  assign in_ready  = !r_out_valid || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_pop     = r_out_valid && out_ready;
  assign w_first   = (r_cnt == '0);
  assign w_last_in = (r_cnt == CW'(FRAME-1));
  assign w_clamp   = (shift_amt > SHW'(MAX_SHIFT)) ? SHW'(MAX_SHIFT) : shift_amt;
  assign w_s       = w_first ? w_clamp : r_slat;
  assign w_re      = f_scale(in_re, w_s);
  assign w_im      = f_scale(in_im, w_s);
  assign w_g       = (w_re[W-1] != w_re[W-2]) || (w_im[W-1] != w_im[W-2]);
  // Growth history restarts once the previous frame's last sample leaves.
  assign w_gbase   = (w_pop && r_out_last) ? 1'b0 : r_grow_acc;

  // Frame position counter and per-frame shift latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_slat <= '0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_first) r_slat <= w_clamp;
    end
  end

  // Single output register: load on accept, drop valid on pop, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_re    <= w_re;
      r_out_im    <= w_im;
      r_out_last  <= w_last_in;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // OR-accumulate growth over the frame; report it with the last sample only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grow_acc <= 1'b0;
      r_grow     <= 1'b0;
    end else if (w_acc) begin
      r_grow_acc <= w_gbase | w_g;
      r_grow     <= w_last_in & (w_gbase | w_g);
    end else begin
      r_grow_acc <= w_gbase;
      if (w_pop) r_grow <= 1'b0;
    end
  end

  // Exponent accumulator: add the new shift at frame start; clear takes priority then adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp <= '0;
    end else if (exp_clr) begin
      r_exp <= (w_acc && w_first) ? EXPW'(w_clamp) : '0;
    end else if (w_acc && w_first) begin
      r_exp <= r_exp + EXPW'(w_clamp);
    end
  end

  assign out_valid = r_out_valid;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_last  = r_out_last;
  assign grow_flag = r_grow;
  assign frame_exp = r_exp;
endmodule

// File: doc/bfp_shift_scaler.md
Name: bfp_shift_scaler

Overview:
- Registered, streaming, block-floating-point scaler for the FFT datapath.
- Generalises the fixed-shift arithmetic right shifter: runtime shift amount latched once per frame, complex (re/im) lanes, optional rounding, valid/ready handshake.
- Tracks frame position and accumulated exponent, and flags growth for the next butterfly stage.
- Sits between FFT butterfly stages; one instance per stage.

Parameters:
- W, 16, sample width per lane, two's complement.
- FRAME, 8, samples per frame; power of 2, at least 2.
- SHW, 3, width of the shift_amt port.
- MAX_SHIFT, 3, largest applied shift; requests above this are clamped.
- EXPW, 8, width of the frame_exp accumulator.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_re  in  W  real input.
- in_im  in  W  imaginary input.
- shift_amt  in  SHW  requested right-shift; sampled only on the first accepted sample of a frame.
- exp_clr  in  1  clears frame_exp.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_re  out  W  scaled real.
- out_im  out  W  scaled imaginary.
- out_last  out  1  marks output sample index FRAME-1.
- grow_flag  out  1  frame needs a shift at the next stage; valid with out_last.
- frame_exp  out  EXPW  sum of shifts applied since reset or clear.

Behaviour:
- Reset (sync, rst=1 at clk edge) clears: out_valid, out_re, out_im, out_last, grow_flag, frame_exp, sample counter, latched shift, grow accumulator. All are 0 after reset.
- Reset overrides everything and aborts any frame in progress; no partial output is emitted afterwards.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, combinational ready).
  - Accept when in_valid && in_ready. Latency is 1 cycle from accept to out_valid.
  - While out_valid && !out_ready, all outputs hold stable.
  - Simultaneous pop and push is allowed: full throughput of 1 sample per clock.
- Frame counter cnt (log2 FRAME bits):
  - Increments on each accept; wraps from FRAME-1 to 0.
  - On an accept with cnt==0: s_lat = min(shift_amt, MAX_SHIFT), and frame_exp += s_lat (wraps modulo 2^EXPW).
  - The shift in use for the current accept is s_lat if cnt!=0, otherwise the new clamped value. shift_amt changes mid-frame are ignored.
  - exp_clr sets frame_exp to 0. If it coincides with an increment, frame_exp = s_lat (clear then add).
- Arithmetic, per lane, with shift s:
  - Sign-extend to W+1 bits, add bias, arithmetic shift right by s, take the low W bits.
  - s=0: bias is 0, exact passthrough.
  - s>0: bias is 2^(s-1) when rounding is enabled, 0 otherwise.
  - No overflow is possible for s>=1, since the result is at most 2^(W-1)-1. No saturation logic is needed.
  - Negative values shift with sign fill.
- Growth detection:
  - g = (out_re[W-1] != out_re[W-2]) || (out_im[W-1] != out_im[W-2]), evaluated on each registered output sample.
  - Accumulate g by OR over the frame into grow_acc.
  - grow_flag = grow_acc including the current sample; asserted only alongside out_last, 0 otherwise.
  - grow_acc clears when the sample with out_last is popped.
- out_last = 1 on the output sample whose input index was FRAME-1.

Optional Feature:
- Macro BFP_ROUND_EN.
- Defined: round-half-up; bias 2^(s-1) for s>0.
- Undefined: truncation (floor); bias 0, and the adder logic is removed.
- Handshake, framing, exponent and growth logic are identical either way.

Test Plan:
- Rounding, s=1:
  - in_re=0x0003 -> out_re=0x0002 with BFP_ROUND_EN, 0x0001 without.
  - in_re=0xFFFD -> out_re=0xFFFF with BFP_ROUND_EN, 0xFFFE without.
- Extremes, s=3:
  - in_re=0x7FFF -> 0x1000 rounded, 0x0FFF truncated.
  - in_im=0x8000 -> 0xF000 in both modes.
  - s=0 passes 0x1234 unchanged.
- Backpressure: stream 8 samples, hold out_ready=0 for 3 cycles after the 2nd output.
  - out_* stays stable and in_ready=0 for those 3 cycles.
  - All 8 outputs arrive in order, no loss or duplication, out_last on the 8th.
- Frame latching: shift_amt=2 at sample 0, changed to 1 at sample 3.
  - All 8 samples use shift 2; frame_exp goes 0->2.
  - Next frame with shift_amt=7 uses 3 (clamped); frame_exp=5.
- Growth: one frame with a single input 0x7FFF at s=0 (output 0x7FFF, top bits 0/1) -> grow_flag=1 with out_last. Next all-zero frame -> grow_flag=0.
- Reset mid-frame: rst=1 after sample 4 is accepted.
  - Next cycle: out_valid=0, frame_exp=0, grow_flag=0.
  - The next accepted sample is treated as index 0 and latches shift_amt.
  - out_last appears on the 8th sample after reset.
